// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exception_sequencer
//  Purpose  : Multi-cycle exception/interrupt controller for the single-cycle
//             MIPS core. It latches the four exception sources into sticky
//             pending bits. It applies a per-source mask and fixed priority.
//             It then sequences entry (EPC capture, vector redirect), handler
//             residency and return (EPC redirect, pending clear).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   system clock, rising edge
//    reset         in   1   synchronous active-low reset
//    irq_in        in   4   {syscall, invalid, overflow, ext_int}
//    retire        in   1   instruction completes; pc_next valid
//    pc_next       in   DW  resume address the core would load next
//    eret          in   1   return-from-exception decoded
//    mask_we       in   1   mask write strobe
//    mask_wd       in   4   new mask (1 = enabled), irq_in bit order
//    redirect_vec  out  1   core loads vector_pc this cycle
//    redirect_epc  out  1   core loads epc this cycle
//    vector_pc     out  DW  VEC_BASE + cause*VEC_STRIDE
//    epc           out  DW  saved resume address
//    cause         out  2   0 syscall, 1 invalid, 2 overflow, 3 ext_int
//    pending       out  4   sticky pending bits
//    mask          out  4   current mask
//    in_handler    out  1   high in SAVE and HANDLER
// ============================================================================
module exception_sequencer #(
  parameter int            DW         = 32,
  parameter logic [DW-1:0] VEC_BASE   = 32'h0000_0180,
  parameter logic [DW-1:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    irq_in,
  input  logic          retire,
  input  logic [DW-1:0] pc_next,
  input  logic          eret,
  input  logic          mask_we,
  input  logic [3:0]    mask_wd,
  output logic          redirect_vec,
  output logic          redirect_epc,
  output logic [DW-1:0] vector_pc,
  output logic [DW-1:0] epc,
  output logic [1:0]    cause,
  output logic [3:0]    pending,
  output logic [3:0]    mask,
  output logic          in_handler
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_HANDLER = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_pending;
  logic [3:0]    r_mask;
  logic [DW-1:0] r_epc;
  logic [1:0]    r_cause;

  logic [3:0]    w_eligible;
  logic [1:0]    w_sel;
  logic [3:0]    w_clr;
  logic [3:0]    w_pending_nxt;

  assign w_eligible = r_pending & r_mask;

  // Cause numbers run opposite to bit order: cause 0 (syscall) is bit 3.
  // The lowest cause number wins, so scan from the top bit down.
  always_comb begin
    w_sel = 2'd3;
    if (w_eligible[3])      w_sel = 2'd0;
    else if (w_eligible[2]) w_sel = 2'd1;
    else if (w_eligible[1]) w_sel = 2'd2;
    else                    w_sel = 2'd3;
  end

  // The serviced bit is cleared only while leaving RETURN. OR-ing irq_in
  // afterwards lets a same-cycle re-assertion win over the clear.
  assign w_clr         = (r_state == S_RETURN) ? (4'b1000 >> r_cause) : 4'b0000;
  assign w_pending_nxt = (r_pending & ~w_clr) | irq_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pending <= 4'b0000;
      r_mask    <= 4'b1111;
      r_epc     <= '0;
      r_cause   <= 2'd0;
    end else begin
      r_pending <= w_pending_nxt;
      if (mask_we) begin
        r_mask <= mask_wd;
      end
      case (r_state)
        S_IDLE: begin
          // Entry waits for a retiring instruction so pc_next is a valid
          // resume point; otherwise the request just stays pending.
          if ((w_eligible != 4'b0000) && retire) begin
            r_epc   <= pc_next;
            r_cause <= w_sel;
            r_state <= S_SAVE;
          end
        end
        S_SAVE: begin
          r_state <= S_HANDLER;
        end
        S_HANDLER: begin
          // No nesting: new requests only accumulate in pending here.
          if (eret) begin
            r_state <= S_RETURN;
          end
        end
        S_RETURN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign redirect_vec = (r_state == S_SAVE);
  assign redirect_epc = (r_state == S_RETURN);
  assign in_handler   = (r_state == S_SAVE) || (r_state == S_HANDLER);
  assign vector_pc    = VEC_BASE + ({{(DW-2){1'b0}}, r_cause} * VEC_STRIDE);
  assign epc          = r_epc;
  assign cause        = r_cause;
  assign pending      = r_pending;
  assign mask         = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exception_sequencer
//  Purpose  : Self-checking bench for exception_sequencer. A behavioural
//             model of the controller is stepped on every clock edge and all
//             outputs are compared with it. Directed scenarios are followed by
//             a randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exception_sequencer;

  localparam logic [31:0] VB = 32'h0000_0180;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        retire;
  logic [31:0] pc_next;
  logic        eret;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        redirect_vec;
  logic        redirect_epc;
  logic [31:0] vector_pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic [3:0]  pending;
  logic [3:0]  mask;
  logic        in_handler;

  int checks = 0;
  int errors = 0;

  exception_sequencer #(
    .DW(32), .VEC_BASE(VB), .VEC_STRIDE(VS)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .retire(retire),
    .pc_next(pc_next), .eret(eret), .mask_we(mask_we), .mask_wd(mask_wd),
    .redirect_vec(redirect_vec), .redirect_epc(redirect_epc),
    .vector_pc(vector_pc), .epc(epc), .cause(cause), .pending(pending),
    .mask(mask), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  // Reference model. phase: 0 waiting, 1 entering (vector), 2 in handler,
  // 3 returning (epc). Causes are numbered 0..3, with cause c on irq bit 3-c.
  int          m_phase;
  logic [3:0]  m_pend;
  logic [3:0]  m_mask;
  logic [31:0] m_epc;
  int          m_cause;

  task automatic model_edge();
    int          sel;
    logic [3:0]  p;
    if (!reset) begin
      m_phase = 0; m_pend = 4'b0000; m_mask = 4'b1111; m_epc = 0; m_cause = 0;
    end else begin
      sel = -1;
      for (int c = 0; c < 4; c++)
        if (sel < 0 && m_pend[3-c] && m_mask[3-c]) sel = c;
      p = m_pend;
      if (m_phase == 3) p[3-m_cause] = 1'b0;
      p = p | irq_in;
      if (mask_we) m_mask = mask_wd;
      case (m_phase)
        0: if (sel >= 0 && retire) begin
             m_epc = pc_next; m_cause = sel; m_phase = 1;
           end
        1: m_phase = 2;
        2: if (eret) m_phase = 3;
        default: m_phase = 0;
      endcase
      m_pend = p;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: the model sees the same inputs as the DUT at the edge, and
  // outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("redirect_vec", {31'd0, redirect_vec}, {31'd0, m_phase == 1});
    chk("redirect_epc", {31'd0, redirect_epc}, {31'd0, m_phase == 3});
    chk("in_handler",   {31'd0, in_handler},   {31'd0, (m_phase == 1) || (m_phase == 2)});
    chk("pending",      {28'd0, pending},      {28'd0, m_pend});
    chk("mask",         {28'd0, mask},         {28'd0, m_mask});
    chk("epc",          epc,                   m_epc);
    chk("cause",        {30'd0, cause},        m_cause);
    chk("vector_pc",    vector_pc,             VB + m_cause * VS);
  endtask

  task automatic finish_handler();
    retire = 1'b0;
    cyc();               // HANDLER
    eret = 1'b1;
    cyc();               // RETURN
    eret = 1'b0;
    cyc();               // back to IDLE
  endtask

  initial begin
    reset = 1'b0; irq_in = 4'b0; retire = 1'b0; pc_next = 32'h0;
    eret = 1'b0; mask_we = 1'b0; mask_wd = 4'b0;
    m_phase = 0; m_pend = 4'b0; m_mask = 4'b1111; m_epc = 0; m_cause = 0;

    // Reset held for two cycles
    cyc(); cyc();
    chk("rst_pending", {28'd0, pending}, 32'h0);
    chk("rst_mask",    {28'd0, mask},    32'hF);
    chk("rst_epc",     epc,              32'h0);
    chk("rst_redir",   {30'd0, redirect_vec, redirect_epc}, 32'h0);
    reset = 1'b1;

    // Single syscall: edge t, SAVE at t+2
    irq_in = 4'b1000; retire = 1'b1; pc_next = 32'h0040_0020;
    cyc();
    irq_in = 4'b0000;
    cyc();
    chk("sys_vec",   {31'd0, redirect_vec}, 32'h1);
    chk("sys_vpc",   vector_pc,             32'h0000_0180);
    chk("sys_cause", {30'd0, cause},        32'h0);
    chk("sys_epc",   epc,                   32'h0040_0020);
    retire = 1'b0;
    cyc();
    eret = 1'b1;
    cyc();
    chk("sys_ret", {31'd0, redirect_epc}, 32'h1);
    eret = 1'b0;
    cyc();
    chk("sys_pend_clr", {28'd0, pending}, 32'h0);

    // Priority and queueing: overflow beats ext_int, then a one-cycle gap
    irq_in = 4'b0011; retire = 1'b1; pc_next = 32'h0040_0100;
    cyc();
    irq_in = 4'b0000;
    cyc();
    chk("pri_cause", {30'd0, cause}, 32'h2);
    chk("pri_vpc",   vector_pc,      32'h0000_01A0);
    cyc();
    eret = 1'b1;
    cyc();
    eret = 1'b0;
    cyc();
    chk("gap_idle", {31'd0, in_handler}, 32'h0);
    cyc();
    chk("q_cause", {30'd0, cause}, 32'h3);
    chk("q_vpc",   vector_pc,      32'h0000_01B0);
    finish_handler();

    // Masking blocks selection but not capture
    mask_we = 1'b1; mask_wd = 4'b1110;
    cyc();
    mask_we = 1'b0; irq_in = 4'b0001; retire = 1'b1;
    cyc();
    irq_in = 4'b0000;
    cyc(); cyc();
    chk("msk_novec", {31'd0, redirect_vec}, 32'h0);
    chk("msk_pend",  {28'd0, pending},      32'h1);
    mask_we = 1'b1; mask_wd = 4'hF;
    cyc();
    mask_we = 1'b0;
    cyc();
    chk("unmsk_vec", {31'd0, redirect_vec}, 32'h1);
    finish_handler();

    // No retire: stay idle, then capture pc_next of the first retire cycle
    irq_in = 4'b0100; retire = 1'b0;
    cyc();
    irq_in = 4'b0000;
    repeat (5) begin
      pc_next = $urandom;
      cyc();
      chk("nr_idle", {31'd0, in_handler}, 32'h0);
    end
    retire = 1'b1; pc_next = 32'h0040_1234;
    cyc();
    chk("nr_epc",   epc,            32'h0040_1234);
    chk("nr_cause", {30'd0, cause}, 32'h1);
    pc_next = 32'h0;
    finish_handler();

    // Syscall re-asserted while its RETURN clears it: set wins
    irq_in = 4'b1000; retire = 1'b1; pc_next = 32'h0040_2000;
    cyc();
    irq_in = 4'b0000;
    cyc();
    retire = 1'b0;
    cyc();
    eret = 1'b1;
    cyc();
    eret = 1'b0; irq_in = 4'b1000;
    cyc();
    chk("setwin_pend", {28'd0, pending}, 32'h8);
    irq_in = 4'b0000; retire = 1'b1;
    cyc();
    chk("setwin_vec", {31'd0, redirect_vec}, 32'h1);
    retire = 1'b0;
    cyc();

    // Reset while in the handler abandons it without a return redirect
    reset = 1'b0;
    cyc();
    chk("rstmid_inh",  {31'd0, in_handler},   32'h0);
    chk("rstmid_pend", {28'd0, pending},      32'h0);
    reset = 1'b1; eret = 1'b1;
    cyc();
    chk("rstmid_noepc", {31'd0, redirect_epc}, 32'h0);
    eret = 1'b0;

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 99) != 0);
      irq_in  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      retire  = ($urandom_range(0, 2) != 0);
      pc_next = $urandom;
      eret    = ($urandom_range(0, 3) == 0);
      mask_we = ($urandom_range(0, 19) == 0);
      mask_wd = 4'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
